bus_mm_arbiter: RTL and testbench



---
 rtl/bus_mm_arbiter_pkg.sv | 29 ++
 rtl/bus_mm_arbiter_if.sv | 38 +++
 rtl/bus_mm_arbiter_rr_pick.sv | 66 ++++++
 rtl/bus_mm_arbiter.sv | 110 +++++++++++
 tb/tb_bus_mm_arbiter.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/bus_mm_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// bus_arb_pkg
// Shared types and defaults for the bus_MM write arbiter (bus_mm_arbiter).
//   arb_state_e   : arbiter FSM states (ARB_IDLE, ARB_OWN)
//   *_DEF         : default N_REQ / AW / DW / MAX_BURST values
//   ARB_IDLE_OUT  : bit value driven on every slave-side output while idle
//   wrap_idx()    : modulo-N index helper used by the round-robin scan
// -----------------------------------------------------------------------------
package bus_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_OWN  = 1'b1
    } arb_state_e;

    localparam int N_REQ_DEF     = 4;
    localparam int AW_DEF        = 8;
    localparam int DW_DEF        = 8;
    localparam int MAX_BURST_DEF = 4;

    // Every slave-side output is forced to this bit value when nobody owns the bus.
    localparam logic ARB_IDLE_OUT = 1'b0;

    // (base + off) mod n; base and off are small non-negative values.
    function automatic int wrap_idx(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/bus_mm_arbiter_if.sv
// -----------------------------------------------------------------------------
// bus_mm_arbiter_if
// Bundle of the requester-side and slave-side bus_MM signals around the arbiter.
//   req/m_address/m_write/m_writedata : per-requester inputs to the arbiter
//   gnt                               : one-hot grant back to the requesters
//   s_address/s_write/s_writedata     : forwarded write to the single slave
//   s_waitrequest                     : slave stall
// Modports:
//   slave  : the arbiter's view (it is the slave of the N masters)
//   master : the environment's view (masters plus the downstream slave)
// -----------------------------------------------------------------------------
interface bus_mm_arbiter_if #(
    parameter int N_REQ = bus_arb_pkg::N_REQ_DEF,
    parameter int AW    = bus_arb_pkg::AW_DEF,
    parameter int DW    = bus_arb_pkg::DW_DEF
);

    logic [N_REQ-1:0]         req;
    logic [N_REQ-1:0][AW-1:0] m_address;
    logic [N_REQ-1:0]         m_write;
    logic [N_REQ-1:0][DW-1:0] m_writedata;
    logic [N_REQ-1:0]         gnt;
    logic [AW-1:0]            s_address;
    logic                     s_write;
    logic [DW-1:0]            s_writedata;
    logic                     s_waitrequest;

    modport slave (
        input  req, m_address, m_write, m_writedata, s_waitrequest,
        output gnt, s_address, s_write, s_writedata
    );

    modport master (
        output req, m_address, m_write, m_writedata, s_waitrequest,
        input  gnt, s_address, s_write, s_writedata
    );

endinterface

// File: rtl/bus_mm_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational winner selection for bus_mm_arbiter.
//   req        in  N_REQ  pending requests
//   last_owner in  IW     previous owner (start point of the rotation)
//   winner     out IW     index of the selected requester
//   valid      out 1      at least one request pending
// Policy is chosen by macro BUS_ARB_FIXED_PRIO_EN:
//   defined   : lowest-index request wins, last_owner ignored
//   undefined : first request found scanning last_owner+1, +2, ... mod N_REQ
// -----------------------------------------------------------------------------
module rr_pick
    import bus_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last_owner,
    output logic [IW-1:0]    winner,
    output logic             valid
);

`ifdef BUS_ARB_FIXED_PRIO_EN

    logic unused_last_owner;
    assign unused_last_owner = ^last_owner;

    // Descending scan so the lowest set index is the last (winning) assignment.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                winner = IW'(i);
                valid  = 1'b1;
            end
        end
    end

`else

    // rot[k] is the request of the requester k+1 positions after last_owner,
    // so a plain priority encode of rot implements the rotation.
    logic [N_REQ-1:0] rot;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
        logic [IW-1:0] idx;
        assign idx     = IW'(wrap_idx(int'(last_owner), gi + 1, N_REQ));
        assign rot[gi] = req[idx];
    end

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                winner = IW'(wrap_idx(int'(last_owner), k + 1, N_REQ));
                valid  = 1'b1;
            end
        end
    end

`endif

endmodule

// File: rtl/bus_mm_arbiter.sv
// -----------------------------------------------------------------------------
// bus_mm_arbiter
// Shares one bus_MM slave port between N_REQ write masters. One requester owns
// the bus at a time, for at most MAX_BURST accepted writes; a one-cycle idle
// bubble separates consecutive owners.
// Ports:
//   CLK    in  system clock
//   reset  in  synchronous, active-high reset
//   bus    slave modport of bus_mm_arbiter_if (requesters + slave signals)
// Optional feature: BUS_ARB_FIXED_PRIO_EN selects fixed lowest-index priority
// instead of round-robin (last_owner then stays at its reset value).
// gnt is registered; slave-side outputs are muxed from the owner's inputs.
// -----------------------------------------------------------------------------
module bus_mm_arbiter
    import bus_arb_pkg::*;
#(
    parameter int N_REQ     = N_REQ_DEF,
    parameter int AW        = AW_DEF,
    parameter int DW        = DW_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input logic              CLK,
    input logic              reset,
    bus_mm_arbiter_if.slave  bus
);

    localparam int IW = $clog2(N_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);

    arb_state_e       state_reg;
    logic [IW-1:0]    owner_reg;
    logic [IW-1:0]    last_owner_reg;
    logic [BW-1:0]    beat_reg;
    logic [N_REQ-1:0] gnt_reg;

    logic [IW-1:0]    winner;
    logic             winner_valid;
    logic             accept;
    logic             at_limit;
    logic             release_own;

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .req        (bus.req),
        .last_owner (last_owner_reg),
        .winner     (winner),
        .valid      (winner_valid)
    );

    assign accept   = (state_reg == ARB_OWN) && bus.s_write && !bus.s_waitrequest;
    assign at_limit = (beat_reg == BW'(MAX_BURST - 1));
    // A stalled write never reaches the limit branch, so the owner holds it
    // until the slave accepts it or the requester gives up.
    assign release_own = !bus.req[owner_reg] || (accept && at_limit);

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_reg      <= ARB_IDLE;
            owner_reg      <= '0;
            last_owner_reg <= IW'(N_REQ - 1);
            beat_reg       <= '0;
            gnt_reg        <= '0;
        end else begin
            case (state_reg)
                ARB_IDLE: begin
                    if (winner_valid) begin
                        state_reg <= ARB_OWN;
                        owner_reg <= winner;
                        beat_reg  <= '0;
                        gnt_reg   <= N_REQ'(1) << winner;
                    end
                end
                ARB_OWN: begin
                    if (accept) begin
                        beat_reg <= beat_reg + BW'(1);
                    end
                    if (release_own) begin
                        state_reg <= ARB_IDLE;
                        gnt_reg   <= '0;
`ifndef BUS_ARB_FIXED_PRIO_EN
                        last_owner_reg <= owner_reg;
`endif
                    end
                end
                default: begin
                    state_reg <= ARB_IDLE;
                    gnt_reg   <= '0;
                end
            endcase
        end
    end

    assign bus.gnt = gnt_reg;

    // Only the owner's signals reach the slave; everything is parked at zero
    // while idle so a stale write can never leak out during the bubble.
    always_comb begin
        bus.s_address   = {AW{ARB_IDLE_OUT}};
        bus.s_writedata = {DW{ARB_IDLE_OUT}};
        bus.s_write     = ARB_IDLE_OUT;
        if (state_reg == ARB_OWN) begin
            bus.s_address   = bus.m_address[owner_reg];
            bus.s_writedata = bus.m_writedata[owner_reg];
            bus.s_write     = bus.m_write[owner_reg];
        end
    end

endmodule

// File: tb/tb_bus_mm_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_mm_arbiter
// Table-driven directed bench for bus_mm_arbiter (N_REQ=4, MAX_BURST=4).
// Each vector holds one cycle of inputs plus the expected gnt / s_write; the
// expected address and data follow from the expected owner and the vector tag.
// Address of requester i = 16*i + tag, data = 16*tag + i.
// -----------------------------------------------------------------------------
module tb_bus_mm_arbiter;

    localparam int N_REQ = 4;
    localparam int AW    = 8;
    localparam int DW    = 8;
    localparam int MB    = 4;

`ifdef BUS_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] wr;
        logic       wt;
        logic [3:0] tag;
        logic [3:0] gnt;
        logic       sw;
    } vec_t;

    logic clk;
    logic reset;
    vec_t vecs[$];
    int   n_checks;
    int   n_fail;

    bus_mm_arbiter_if #(.N_REQ(N_REQ), .AW(AW), .DW(DW)) bus ();

    bus_mm_arbiter #(
        .N_REQ     (N_REQ),
        .AW        (AW),
        .DW        (DW),
        .MAX_BURST (MB)
    ) dut (
        .CLK   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic rst, input logic [3:0] req, input logic [3:0] wr,
                       input logic wt, input int tag, input logic [3:0] gnt,
                       input logic sw);
        vec_t v;
        v.rst = rst;
        v.req = req;
        v.wr  = wr;
        v.wt  = wt;
        v.tag = 4'(tag);
        v.gnt = gnt;
        v.sw  = sw;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int vi, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %0h expected %0h", name, vi, act, exp);
        end
    endtask

    function automatic int idx_of(input logic [3:0] g);
        int r;
        r = 0;
        for (int i = 0; i < 4; i++) if (g[i]) r = i;
        return r;
    endfunction

    function automatic logic [3:0] oh(input int i);
        return 4'(1 << i);
    endfunction

    task automatic drive(input vec_t v);
        reset             = v.rst;
        bus.req           = v.req;
        bus.m_write       = v.wr;
        bus.s_waitrequest = v.wt;
        for (int i = 0; i < N_REQ; i++) begin
            bus.m_address[i]   = 8'(16 * i + int'(v.tag));
            bus.m_writedata[i] = 8'(16 * int'(v.tag) + i);
        end
    endtask

    task automatic build_tables();
        int own;
        // Rotation: all four requesting and writing; 4 writes then a bubble.
        for (int c = 0; c < 25; c++) begin
            own = FIXED ? 0 : (c / 5) % 4;
            add(0, 4'b1111, 4'b1111, 0, c % 16,
                (c % 5 == 0) ? 4'b0000 : oh(own), (c % 5) != 0);
        end
        add(1, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0);

        // Single requester 2, ten writes then req dropped.
        for (int c = 0; c < 13; c++)
            add(0, 4'b0100, 4'b0100, 0, c, (c % 5 == 0) ? 4'b0000 : 4'b0100, (c % 5) != 0);
        add(0, 4'b0000, 4'b0000, 0, 13, 4'b0100, 0);
        add(0, 4'b0000, 4'b0000, 0, 14, 4'b0000, 0);

        // Requester 1: fourth write stalled three cycles, held until accepted.
        add(0, 4'b0010, 4'b0010, 0, 0, 4'b0000, 0);
        for (int c = 1; c < 4; c++) add(0, 4'b0010, 4'b0010, 0, c, 4'b0010, 1);
        for (int c = 0; c < 3; c++) add(0, 4'b0010, 4'b0010, 1, 4, 4'b0010, 1);
        add(0, 4'b0010, 4'b0010, 0, 4, 4'b0010, 1);
        add(0, 4'b0010, 4'b0010, 0, 5, 4'b0000, 0);
        add(0, 4'b0000, 4'b0000, 0, 6, 4'b0010, 0);
        add(0, 4'b0000, 4'b0000, 0, 7, 4'b0000, 0);
        add(1, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0);

        // Owner 0 drops req after two writes (write still shown), then 3 gets it.
        add(0, 4'b1001, 4'b1001, 0, 0, 4'b0000, 0);
        add(0, 4'b1001, 4'b1001, 0, 1, 4'b0001, 1);
        add(0, 4'b1001, 4'b1001, 0, 2, 4'b0001, 1);
        add(0, 4'b1000, 4'b1001, 0, 3, 4'b0001, 1);
        add(0, 4'b1000, 4'b1000, 0, 4, 4'b0000, 0);
        add(0, 4'b1000, 4'b1000, 0, 5, 4'b1000, 1);
        add(0, 4'b0000, 4'b0000, 0, 6, 4'b1000, 0);
        add(0, 4'b0000, 4'b0000, 0, 7, 4'b0000, 0);
        add(1, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0);

        // Reset in the middle of requester 2's burst, then 0 before 2.
        add(0, 4'b0100, 4'b0100, 0, 1, 4'b0000, 0);
        add(0, 4'b0100, 4'b0100, 0, 2, 4'b0100, 1);
        add(1, 4'b0100, 4'b0100, 1, 3, 4'b0100, 1);
        add(0, 4'b0101, 4'b0101, 0, 4, 4'b0000, 0);
        for (int c = 5; c < 9; c++) add(0, 4'b0101, 4'b0101, 0, c, 4'b0001, 1);
        add(0, 4'b0101, 4'b0101, 0, 9, 4'b0000, 0);
        add(0, 4'b0101, 4'b0101, 0, 10, FIXED ? 4'b0001 : 4'b0100, 1);
        add(0, 4'b0000, 4'b0000, 0, 11, FIXED ? 4'b0001 : 4'b0100, 0);
        add(0, 4'b0000, 4'b0000, 0, 12, 4'b0000, 0);

        // Two contenders: alternate under round-robin, requester 1 starved when fixed.
        for (int c = 0; c < 20; c++) begin
            own = FIXED ? 0 : (c / 5) % 2;
            add(0, 4'b0011, 4'b0011, 0, c % 16,
                (c % 5 == 0) ? 4'b0000 : oh(own), (c % 5) != 0);
        end
    endtask

    initial begin
        logic [7:0] exp_addr;
        logic [7:0] exp_data;
        vec_t       v;
        int         ix;

        n_checks = 0;
        n_fail   = 0;
        build_tables();

        v = '{rst: 1'b1, req: 4'b0, wr: 4'b0, wt: 1'b0, tag: 4'b0, gnt: 4'b0, sw: 1'b0};
        drive(v);
        repeat (3) @(negedge clk);
        #1;
        check("reset_gnt", -1, 32'(bus.gnt), 32'h0);
        check("reset_s_write", -1, 32'(bus.s_write), 32'h0);
        check("reset_s_address", -1, 32'(bus.s_address), 32'h0);
        check("reset_s_writedata", -1, 32'(bus.s_writedata), 32'h0);

        for (int vi = 0; vi < vecs.size(); vi++) begin
            @(negedge clk);
            v = vecs[vi];
            drive(v);
            #1;
            ix       = idx_of(v.gnt);
            exp_addr = (v.gnt == 4'b0) ? 8'h00 : 8'(16 * ix + int'(v.tag));
            exp_data = (v.gnt == 4'b0) ? 8'h00 : 8'(16 * int'(v.tag) + ix);
            $display("vec %0d rst=%b req=%b wr=%b wt=%b -> gnt=%b s_write=%b addr=%h data=%h",
                     vi, v.rst, v.req, v.wr, v.wt, bus.gnt, bus.s_write,
                     bus.s_address, bus.s_writedata);
            check("gnt", vi, 32'(bus.gnt), 32'(v.gnt));
            check("s_write", vi, 32'(bus.s_write), 32'(v.sw));
            check("s_address", vi, 32'(bus.s_address), 32'(exp_addr));
            check("s_writedata", vi, 32'(bus.s_writedata), 32'(exp_data));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
